shift_left_2: RTL and testbench

//  - Fixed logical left shift by SHIFT bits (default 2). Used in the MIPS datapath to turn a

---
 rtl/shift_left_2_pkg.sv | 7 +
 rtl/shift_left_2_if.sv | 27 ++
 rtl/shift_left_2.sv | 65 ++++++
 tb/tb_shift_left_2.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/shift_left_2_pkg.sv
// rtl/shift_left_2_pkg.sv - datapath constants for the branch-offset left shifter
package shift_left_2_pkg;

  localparam int WORD_W   = 32;
  localparam int BR_SHIFT = 2;

endpackage

// File: rtl/shift_left_2_if.sv
// rtl/shift_left_2_if.sv - operand/result bundle between the datapath and the shifter
interface shift_left_2_if
  import shift_left_2_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHIFT = BR_SHIFT
);

  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out_comb;
  logic [SHIFT-1:0] lost_comb;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             overflow;

  modport master (
    output in_valid, in,
    input  out_comb, lost_comb, out, out_valid, overflow
  );

  modport slave (
    input  in_valid, in,
    output out_comb, lost_comb, out, out_valid, overflow
  );

endinterface

// File: rtl/shift_left_2.sv
// rtl/shift_left_2.sv - fixed logical left shift with combinational result and optional registered copy
module shift_left_2
  import shift_left_2_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int SHIFT   = BR_SHIFT,
  parameter bit REG_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_left_2_if.slave bus
);

  logic [WIDTH-1:0] shifted;
  logic [SHIFT-1:0] lost;

  assign shifted       = {bus.in[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
  assign lost          = bus.in[WIDTH-1:WIDTH-SHIFT];
  assign bus.out_comb  = shifted;
  assign bus.lost_comb = lost;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q, out_d;
      logic             out_valid_q, out_valid_d;
      logic             overflow_q, overflow_d;

      // out_valid depends on in_valid alone so an unknown operand cannot taint it
      always_comb begin
        out_d       = out_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
          out_d       = shifted;
          overflow_d  = |lost;
          out_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
          overflow_q  <= 1'b0;
        end else begin
          out_q       <= out_d;
          out_valid_q <= out_valid_d;
          overflow_q  <= overflow_d;
        end
      end

      assign bus.out       = out_q;
      assign bus.out_valid = out_valid_q;
      assign bus.overflow  = overflow_q;
    end else begin : g_comb
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst_n;
      assign bus.out        = shifted;
      assign bus.out_valid  = bus.in_valid;
      assign bus.overflow   = |lost;
    end
  endgenerate

endmodule

// File: tb/tb_shift_left_2.sv
// tb/tb_shift_left_2.sv - directed bench for shift_left_2, registered and combinational builds
module tb_shift_left_2;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];
  logic [31:0] m_out;
  logic        m_ovf;

  shift_left_2_if #(.WIDTH(32), .SHIFT(2)) bus_r ();
  shift_left_2_if #(.WIDTH(32), .SHIFT(2)) bus_c ();

  shift_left_2 #(.WIDTH(32), .SHIFT(2), .REG_OUT(1'b1)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_r.slave)
  );

  shift_left_2 #(.WIDTH(32), .SHIFT(2), .REG_OUT(1'b0)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] x, input logic v);
    bus_r.in = x; bus_r.in_valid = v;
    bus_c.in = x; bus_c.in_valid = v;
  endtask

  task automatic check_reg(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_out"}, bus_r.out, e.out);
    chk({tag, "_ovf"}, {31'd0, bus_r.overflow}, {31'd0, e.ovf});
    chk({tag, "_vld"}, {31'd0, bus_r.out_valid}, {31'd0, e.vld});
  endtask

  // one directed step: drive at negedge, check comb paths, then the registered copy after the edge
  task automatic step(input string tag, input logic [31:0] x, input logic v, input logic [31:0] want);
    logic       want_ovf;
    logic [1:0] want_lost;
    exp_t       e;
    want_ovf  = (x >= 32'h4000_0000);
    want_lost = 2'(x >> 30);
    @(negedge clk);
    set_in(x, v);
    #1;
    chk({tag, "_comb"}, bus_r.out_comb, want);
    chk({tag, "_lost"}, {30'd0, bus_r.lost_comb}, {30'd0, want_lost});
    chk({tag, "_c_out"}, bus_c.out, want);
    chk({tag, "_c_vld"}, {31'd0, bus_c.out_valid}, {31'd0, v});
    chk({tag, "_c_ovf"}, {31'd0, bus_c.overflow}, {31'd0, want_ovf});
    if (v) begin
      m_out = want;
      m_ovf = want_ovf;
    end
    e.out = m_out; e.ovf = m_ovf; e.vld = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_reg(tag);
  endtask

  initial begin
    logic [31:0] r;
    exp_t e;
    rst_n = 1'b0;
    m_out = '0;
    m_ovf = 1'b0;
    set_in(32'd0, 1'b0);
    #1;
    chk("rst_out", bus_r.out, 32'd0);
    chk("rst_vld", {31'd0, bus_r.out_valid}, 32'd0);
    chk("rst_ovf", {31'd0, bus_r.overflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("in6",     32'd6,          1'b1, 32'd24);
    step("in100",   32'd100,        1'b1, 32'd400);
    step("in12100", 32'd12100,      1'b1, 32'h0000_BD10);
    step("inC01",   32'hC000_0001,  1'b1, 32'h0000_0004);
    step("hold",    32'h1234_5678,  1'b0, 32'h48D1_59E0);
    step("zero",    32'd0,          1'b1, 32'd0);
    step("ones",    32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFC);

    // unknown operand while idle: registered value holds, valid stays low
    @(negedge clk);
    set_in('x, 1'b0);
    #1;
    chk("xin_c_vld", {31'd0, bus_c.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("xin_vld", {31'd0, bus_r.out_valid}, 32'd0);
    chk("xin_out", bus_r.out, 32'hFFFF_FFFC);
    chk("xin_ovf", {31'd0, bus_r.overflow}, 32'd1);

    step("pre_rst", 32'd100, 1'b1, 32'd400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", bus_r.out, 32'd0);
    chk("async_rst_vld", {31'd0, bus_r.out_valid}, 32'd0);
    chk("async_rst_ovf", {31'd0, bus_r.overflow}, 32'd0);
    chk("async_rst_comb", bus_r.out_comb, 32'd400);
    m_out = '0;
    m_ovf = 1'b0;
    rst_n = 1'b1;
    step("post_rst6", 32'd6, 1'b1, 32'd24);

    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      step("rand", r, 1'($urandom_range(0, 1)), r * 32'd4);
    end

    @(negedge clk);
    set_in(32'd0, 1'b0);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
